// File: rtl/life_ctrl_if.sv
// life_ctrl_if: control/data bundle between life_ctrl and its environment.
//   master : drives seed handshake, run control, pacing, and the evolve
//            engine result (grid_next); observes grid and status.
//   slave  : life_ctrl side.
//   Signals: seed_valid/seed_ready/seed_grid, start, gen_limit, tick_en,
//            abort, grid_q, grid_next, busy, done, stable, extinct, gen_cnt.
interface life_ctrl_if #(
  parameter int unsigned GEN_W = 8
);
  localparam int unsigned GRID_W = 64;

  logic              seed_valid;
  logic              seed_ready;
  logic [GRID_W-1:0] seed_grid;
  logic              start;
  logic [GEN_W-1:0]  gen_limit;
  logic              tick_en;
  logic              abort;
  logic [GRID_W-1:0] grid_q;
  logic [GRID_W-1:0] grid_next;
  logic              busy;
  logic              done;
  logic              stable;
  logic              extinct;
  logic [GEN_W-1:0]  gen_cnt;

  modport master (
    output seed_valid, seed_grid, start, gen_limit, tick_en, abort, grid_next,
    input  seed_ready, grid_q, busy, done, stable, extinct, gen_cnt
  );

  modport slave (
    input  seed_valid, seed_grid, start, gen_limit, tick_en, abort, grid_next,
    output seed_ready, grid_q, busy, done, stable, extinct, gen_cnt
  );
endinterface

// File: rtl/life_ctrl.sv
// life_ctrl: sequencer for an 8x8 Game of Life engine.
//   Holds the current generation, loads seeds over a valid/ready handshake,
//   commits the external combinational engine's result on each paced tick,
//   and stops on generation limit, stability, extinction (unlimited runs)
//   or abort, reporting the reason.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - life_ctrl_if.slave (seed handshake, run control, grid, status)
module life_ctrl #(
  parameter int unsigned GEN_W = 8
) (
  input logic        clk,
  input logic        rst_n,
  life_ctrl_if.slave bus
);

  localparam int unsigned GRID_W = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [GRID_W-1:0] r_grid;
  logic [GEN_W-1:0]  r_gen;
  logic [GEN_W-1:0]  r_target;
  logic              r_busy;
  logic              r_done;
  logic              r_stable;
  logic              r_extinct;

  logic [GRID_W-1:0] w_grid_d;
  logic [GEN_W-1:0]  w_gen_d;
  logic [GEN_W-1:0]  w_target_d;
  logic              w_done_d;
  logic              w_stable_d;
  logic              w_extinct_d;

  // One extra bit so the limit compare never aliases on wrap.
  logic [GEN_W:0]    w_gen_inc;
  logic [GEN_W-1:0]  w_gen_sat;
  logic              w_still;
  logic              w_limit_hit;
  logic              w_dead_end;

  // Run-termination conditions derived from the engine result.
  always_comb begin
    w_gen_inc   = {1'b0, r_gen} + (GEN_W+1)'(1);
    w_gen_sat   = w_gen_inc[GEN_W] ? r_gen : w_gen_inc[GEN_W-1:0];
    w_still     = (bus.grid_next == r_grid);
    w_limit_hit = (r_target != '0) && (w_gen_inc == {1'b0, r_target});
    w_dead_end  = (r_target == '0) && (bus.grid_next == '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a load in IDLE masks a simultaneous start.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.seed_valid) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort ||
            (bus.tick_en && (w_still || w_limit_hit || w_dead_end))) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output/datapath next values.
  always_comb begin
    w_grid_d    = r_grid;
    w_gen_d     = r_gen;
    w_target_d  = r_target;
    w_done_d    = 1'b0;
    w_stable_d  = r_stable;
    w_extinct_d = r_extinct;
    case (r_state)
      ST_IDLE: begin
        if (bus.seed_valid) begin
          w_grid_d    = bus.seed_grid;
          w_gen_d     = '0;
          w_stable_d  = 1'b0;
          w_extinct_d = 1'b0;
        end else if (bus.start) begin
          w_target_d  = bus.gen_limit;
          w_gen_d     = '0;
          w_stable_d  = 1'b0;
          w_extinct_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          // Abort wins even on non-tick cycles; grid is left as committed.
          w_done_d    = 1'b1;
          w_stable_d  = 1'b0;
          w_extinct_d = (r_grid == '0);
        end else if (bus.tick_en) begin
          if (w_still) begin
            // Fixed point: nothing to commit, report stability.
            w_done_d    = 1'b1;
            w_stable_d  = 1'b1;
            w_extinct_d = (r_grid == '0);
          end else begin
            w_grid_d = bus.grid_next;
            w_gen_d  = w_gen_sat;
            if (w_limit_hit) begin
              w_done_d    = 1'b1;
              w_extinct_d = (bus.grid_next == '0);
            end else if (w_dead_end) begin
              w_done_d    = 1'b1;
              w_extinct_d = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Registered datapath and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grid    <= '0;
      r_gen     <= '0;
      r_target  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_stable  <= 1'b0;
      r_extinct <= 1'b0;
    end else begin
      r_grid    <= w_grid_d;
      r_gen     <= w_gen_d;
      r_target  <= w_target_d;
      r_busy    <= (w_state_next == ST_RUN);
      r_done    <= w_done_d;
      r_stable  <= w_stable_d;
      r_extinct <= w_extinct_d;
    end
  end

  assign bus.seed_ready = (r_state == ST_IDLE);
  assign bus.grid_q     = r_grid;
  assign bus.gen_cnt    = r_gen;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.stable     = r_stable;
  assign bus.extinct    = r_extinct;

endmodule

// File: tb/tb_life_ctrl.sv
// tb_life_ctrl: directed bench for life_ctrl with a reference Game of Life
// engine (dead border) closing the loop from grid_q to grid_next.
module tb_life_ctrl;

  localparam int unsigned GEN_W = 8;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
  localparam logic [63:0] SINGLE  = 64'h0000_0000_0800_0000;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   ticks;

  life_ctrl_if #(.GEN_W(GEN_W)) bus ();

  life_ctrl #(.GEN_W(GEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] evolve(input logic [63:0] g);
    logic [63:0] n;
    int          cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                (c + dc) >= 0 && (c + dc) < 8) begin
              if (g[8*(r+dr) + (c+dc)]) cnt++;
            end
          end
        end
        n[8*r+c] = (cnt == 3) || (g[8*r+c] && cnt == 2);
      end
    end
    return n;
  endfunction

  assign bus.grid_next = evolve(bus.grid_q);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic busy, input logic done,
                            input logic stable, input logic extinct);
    chk({tag, ".busy"},    64'(bus.busy),    64'(busy));
    chk({tag, ".done"},    64'(bus.done),    64'(done));
    chk({tag, ".stable"},  64'(bus.stable),  64'(stable));
    chk({tag, ".extinct"}, 64'(bus.extinct), 64'(extinct));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.seed_valid = 1'b0;
    bus.seed_grid  = '0;
    bus.start      = 1'b0;
    bus.gen_limit  = '0;
    bus.tick_en    = 1'b0;
    bus.abort      = 1'b0;

    // Reset state
    #12;
    chk("rst.seed_ready", 64'(bus.seed_ready), 64'd1);
    chk("rst.grid_q", bus.grid_q, 64'd0);
    chk("rst.gen_cnt", 64'(bus.gen_cnt), 64'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // 1: load with simultaneous start; start must be ignored
    bus.seed_valid = 1'b1;
    bus.seed_grid  = BLINK_H;
    bus.start      = 1'b1;
    bus.gen_limit  = 8'd3;
    step();
    bus.seed_valid = 1'b0;
    bus.start      = 1'b0;
    chk("load.grid_q", bus.grid_q, BLINK_H);
    chk("load.busy", 64'(bus.busy), 64'd0);
    chk("load.seed_ready", 64'(bus.seed_ready), 64'd1);
    step();
    chk("load.still_idle", 64'(bus.busy), 64'd0);

    // 2: blinker, gen_limit = 3
    bus.start     = 1'b1;
    bus.gen_limit = 8'd3;
    bus.tick_en   = 1'b1;
    step();
    bus.start = 1'b0;
    chk("blk.busy", 64'(bus.busy), 64'd1);
    chk("blk.seed_ready", 64'(bus.seed_ready), 64'd0);
    chk("blk.grid0", bus.grid_q, BLINK_H);
    chk("blk.gen0", 64'(bus.gen_cnt), 64'd0);
    step();
    chk("blk.grid1", bus.grid_q, BLINK_V);
    chk("blk.gen1", 64'(bus.gen_cnt), 64'd1);
    chk("blk.done1", 64'(bus.done), 64'd0);
    step();
    chk("blk.grid2", bus.grid_q, BLINK_H);
    chk("blk.gen2", 64'(bus.gen_cnt), 64'd2);
    chk("blk.done2", 64'(bus.done), 64'd0);
    step();
    chk("blk.grid3", bus.grid_q, BLINK_V);
    chk("blk.gen3", 64'(bus.gen_cnt), 64'd3);
    chk_status("blk.end", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("blk.end.seed_ready", 64'(bus.seed_ready), 64'd1);

    // Back-to-back start in the cycle after done, gen_limit = 1
    bus.start     = 1'b1;
    bus.gen_limit = 8'd1;
    step();
    bus.start = 1'b0;
    chk("b2b.busy", 64'(bus.busy), 64'd1);
    chk("b2b.done_gone", 64'(bus.done), 64'd0);
    chk("b2b.gen0", 64'(bus.gen_cnt), 64'd0);
    step();
    chk("b2b.grid", bus.grid_q, BLINK_H);
    chk("b2b.gen", 64'(bus.gen_cnt), 64'd1);
    chk_status("b2b.end", 1'b0, 1'b1, 1'b0, 1'b0);
    bus.tick_en = 1'b0;
    step();
    chk("b2b.done_1cyc", 64'(bus.done), 64'd0);

    // 3: still life
    bus.seed_valid = 1'b1;
    bus.seed_grid  = BLOCK;
    step();
    bus.seed_valid = 1'b0;
    chk("still.load_gen", 64'(bus.gen_cnt), 64'd0);
    bus.start     = 1'b1;
    bus.gen_limit = 8'd0;
    bus.tick_en   = 1'b1;
    step();
    bus.start = 1'b0;
    chk("still.busy", 64'(bus.busy), 64'd1);
    step();
    chk("still.grid", bus.grid_q, BLOCK);
    chk("still.gen", 64'(bus.gen_cnt), 64'd0);
    chk_status("still.end", 1'b0, 1'b1, 1'b1, 1'b0);
    bus.tick_en = 1'b0;

    // 4: extinction
    bus.seed_valid = 1'b1;
    bus.seed_grid  = SINGLE;
    step();
    bus.seed_valid = 1'b0;
    chk("ext.load_grid", bus.grid_q, SINGLE);
    chk("ext.load_stable_clr", 64'(bus.stable), 64'd0);
    bus.start   = 1'b1;
    bus.tick_en = 1'b1;
    step();
    bus.start = 1'b0;
    chk("ext.busy", 64'(bus.busy), 64'd1);
    step();
    chk("ext.grid", bus.grid_q, 64'd0);
    chk("ext.gen", 64'(bus.gen_cnt), 64'd1);
    chk_status("ext.end", 1'b0, 1'b1, 1'b0, 1'b1);
    bus.tick_en = 1'b0;

    // 5: pacing (one tick in four) then abort on a non-tick cycle
    bus.seed_valid = 1'b1;
    bus.seed_grid  = BLINK_H;
    step();
    bus.seed_valid = 1'b0;
    chk("pace.load_extinct_clr", 64'(bus.extinct), 64'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("pace.busy", 64'(bus.busy), 64'd1);
    ticks = 0;
    for (int k = 0; k < 8; k++) begin
      bus.tick_en = (k % 4 == 0);
      if (k % 4 == 0) ticks++;
      step();
      chk($sformatf("pace.gen[%0d]", k), 64'(bus.gen_cnt), 64'(ticks));
      chk($sformatf("pace.grid[%0d]", k), bus.grid_q, (ticks % 2 == 1) ? BLINK_V : BLINK_H);
      chk($sformatf("pace.busy[%0d]", k), 64'(bus.busy), 64'd1);
    end
    bus.tick_en = 1'b0;
    bus.abort   = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort.grid", bus.grid_q, BLINK_H);
    chk("abort.gen", 64'(bus.gen_cnt), 64'd2);
    chk_status("abort.end", 1'b0, 1'b1, 1'b0, 1'b0);
    // Abort in IDLE does nothing
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("idle_abort.done", 64'(bus.done), 64'd0);
    chk("idle_abort.ready", 64'(bus.seed_ready), 64'd1);

    // 6: asynchronous reset mid-run
    bus.start   = 1'b1;
    bus.tick_en = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("mid.pre_grid", bus.grid_q, BLINK_V);
    chk("mid.pre_busy", 64'(bus.busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.grid", bus.grid_q, 64'd0);
    chk("mid.seed_ready", 64'(bus.seed_ready), 64'd1);
    chk("mid.gen", 64'(bus.gen_cnt), 64'd0);
    chk_status("mid", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("mid.no_done", 64'(bus.done), 64'd0);
    bus.tick_en = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post.idle", 64'(bus.busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/life_ctrl.md
# life_ctrl

Sequential controller for the 8x8 Game of Life engine.
- Holds the current generation in a 64-bit register and accepts a seed grid over a valid/ready handshake.
- Presents the grid to the combinational evolve engine and commits the engine's next-generation result on each paced tick.
- Stops after a programmed generation count, when the pattern becomes stable, or on abort, and reports why it stopped.

## Interface
Parameters:
- GEN_W, 8, width of the generation limit and the generation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seed_valid  in  1  a seed grid is offered.
- seed_ready  out  1  seed can be accepted; equals (state == IDLE).
- seed_grid  in  64  seed; bit 8*r+c is the cell at row r, column c.
- start  in  1  single-cycle request to begin running.
- gen_limit  in  GEN_W  number of generations to run; 0 means run until stable or abort. Sampled on accepted start.
- tick_en  in  1  generation pacing strobe; one advance per high cycle while in RUN.
- abort  in  1  stop a run early.
- grid_q  out  64  current generation; drives the evolve engine input.
- grid_next  in  64  evolve engine output for grid_q.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a run ends.
- stable  out  1  last run ended because grid_next == grid_q.
- extinct  out  1  grid_q == 0 at end of run.
- gen_cnt  out  GEN_W  generations committed since the last load or start.

## Operation
- States: IDLE, RUN. All outputs are registered, except seed_ready.
- IDLE behaviour:
  - seed_valid & seed_ready: grid_q <= seed_grid; gen_cnt, stable and extinct are cleared.
  - A load takes priority. If start is high in the same cycle, start is ignored.
  - start without seed_valid: target <= gen_limit; gen_cnt <= 0; stable and extinct are cleared; go to RUN.
- RUN, cycle with tick_en = 1. Checks are evaluated in this priority order:
  1. abort: go to IDLE, pulse done, grid_q unchanged, stable = 0, extinct = (grid_q == 0).
  2. grid_next == grid_q: do not commit, gen_cnt unchanged, stable <= 1, extinct <= (grid_q == 0), pulse done, go to IDLE.
  3. Otherwise: grid_q <= grid_next and gen_cnt <= gen_cnt + 1, saturating at 2^GEN_W - 1.
     - If target != 0 and gen_cnt + 1 == target: pulse done, extinct <= (grid_next == 0), go to IDLE.
     - If target == 0 and grid_next == 0: pulse done, extinct <= 1, go to IDLE.
- RUN, cycle with tick_en = 0: only abort is acted on; there is no other state change.
- Inputs ignored in RUN: start, seed_valid, and changes to gen_limit.
- abort in IDLE has no effect.
- The limit check fires only on an exact match. Saturation can only occur with target == 0, where the count is informational.

## Timing
- Reset values:
  - state = IDLE, so seed_ready = 1.
  - grid_q = 0, gen_cnt = 0, busy = 0, done = 0, stable = 0, extinct = 0.
  - target = 0.
- Seed latency: grid_q updates on the clock edge that samples the handshake and is visible the next cycle.
- Start latency: start sampled at edge T gives busy = 1 and seed_ready = 0 from T+1.
  - The earliest commit is at the edge after T+1 with tick_en = 1.
- Commit: grid_q takes grid_next at the sampling edge. The engine is combinational, so the next generation is ready one cycle later.
- done and the end-of-run flags update at the terminating edge, along with busy = 0 and seed_ready = 1. done lasts exactly one cycle.
- stable and extinct hold until the next load or start.
- Back-to-back runs: start is accepted in the cycle immediately after done.
- Asynchronous reset mid-run returns every output to its reset value immediately. No done pulse is generated.

## Test plan
Bench wiring: the evolve engine connects grid_q to grid_next.
1. Reset then load: seed 0x0000_0000_1C00_0000 (horizontal blinker), with start in the same cycle.
   - Expect grid_q = seed and busy = 0; start is ignored.
2. Blinker run: start with gen_limit = 3, tick_en = 1 continuously.
   - Expect grid_q to alternate 0x0000_0008_0808_0000 / 0x...1C00_0000 / 0x...0808_0000.
   - Expect gen_cnt = 3, done on the third commit, stable = 0, extinct = 0.
3. Still life: seed block 0x0000_0018_1800_0000, gen_limit = 0.
   - Expect done on the first tick, gen_cnt = 0, stable = 1, grid_q unchanged.
4. Extinction: seed single cell 0x0000_0000_0800_0000, gen_limit = 0.
   - Expect grid_q = 0, gen_cnt = 1, extinct = 1, stable = 0, done after one tick.
5. Pacing and abort: blinker seed, gen_limit = 0, tick_en high one cycle in four.
   - Expect gen_cnt to advance only on tick cycles.
   - Abort on a non-tick cycle: done next edge, grid_q holds its last committed value, stable = 0.
6. Reset mid-run: assert rst_n = 0 during RUN.
   - Expect grid_q = 0, busy = 0, seed_ready = 1, no done pulse, outputs valid before the next clock edge.
